// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencing controller around a serial 1011 Mealy detector; counts matches per frame.
// Optional build macro PATTERN_OVERLAP_EN selects overlapping detection (S101 --1--> S1 instead of S0).
module pattern_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);
    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

    state_t           state_q, state_d;
    det_t             det_q, det_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             ended_q, ended_d;
    logic             x;
    logic             match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            det_q    <= S0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            ended_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            ended_q  <= ended_d;
        end
    end

    // Detector transitions; only consulted while shifting.
    assign x = shreg_q[WIDTH-1];
    always_comb begin
        det_d = det_q;
        match = 1'b0;
        case (det_q)
            S0:   det_d = x ? S1 : S0;
            S1:   det_d = x ? S1 : S10;
            S10:  det_d = x ? S101 : S0;
            S101: begin
                if (x) begin
                    match = 1'b1;
`ifdef PATTERN_OVERLAP_EN
                    det_d = S1;
`else
                    det_d = S0;
`endif
                end else begin
                    det_d = S10;
                end
            end
            default: det_d = S0;
        endcase
        if (state_q == ST_DONE) begin
            det_d = S0;
        end else if (state_q != ST_SHIFT) begin
            det_d = det_q;
            match = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        ended_d  = ended_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d  = in_data;
                    last_d   = in_last;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                    // First word after a finished frame starts a fresh count.
                    if (ended_q) begin
                        cnt_d   = '0;
                        ended_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                if (match) begin
                    hit_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (bitcnt_q == LAST_BIT) begin
                    bitcnt_d = '0;
                    state_d  = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                ended_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign hit       = hit_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized self-checking bench for pattern_scan_ctrl; expected hits come from a substring scan of each frame's bit stream.
module tb_pattern_scan_ctrl;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          hit;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done;

    int vectors    = 0;
    int miscompares = 0;
    logic [W-1:0] frame_q[$];

    pattern_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .hit      (hit),
        .match_cnt(match_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check_val("ready_timeout", 32'(in_ready), 1);
    endtask

    // Reference: find every 1011 in the frame's MSB-first bit stream; non-overlapping scan restarts after a match.
    task automatic run_frame(input string name, input bit gaps);
        logic bits[$];
        int   exp_hit[];
        int   n, i, idx, cnt, step;
        for (int w = 0; w < frame_q.size(); w++)
            for (int b = W - 1; b >= 0; b--) bits.push_back(frame_q[w][b]);
        n = bits.size();
        exp_hit = new[n];
        foreach (exp_hit[k]) exp_hit[k] = 0;
`ifdef PATTERN_OVERLAP_EN
        step = 1;
`else
        step = 4;
`endif
        i = 0;
        while (i + 3 < n) begin
            if (bits[i] && !bits[i+1] && bits[i+2] && bits[i+3]) begin
                exp_hit[i+3] = 1;
                i += step;
            end else begin
                i++;
            end
        end

        cnt = 0;
        idx = 0;
        for (int w = 0; w < frame_q.size(); w++) begin
            bit is_last = (w == frame_q.size() - 1);
            if (gaps) begin
                int g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) begin
                    in_data = W'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = frame_q[w];
            in_last  = is_last;
            wait_ready();
            @(posedge clk);
            #1;
            check_val("busy_after_accept", 32'(busy), 1);
            check_val("ready_after_accept", 32'(in_ready), 0);
            check_val("cnt_after_accept", 32'(match_cnt), 32'(cnt));
            in_data = W'($urandom);
            in_last = 1'($urandom);
            for (int b = 0; b < W; b++) begin
                @(posedge clk);
                #1;
                if (exp_hit[idx] != 0 && cnt < MAXC) cnt++;
                check_val("hit", 32'(hit), 32'(exp_hit[idx]));
                check_val("match_cnt", 32'(match_cnt), 32'(cnt));
                check_val("busy", 32'(busy), (b < W - 1) ? 1 : 0);
                idx++;
            end
            check_val("ready_word_end", 32'(in_ready), is_last ? 0 : 1);
            check_val("done_word_end", 32'(done), is_last ? 1 : 0);
            $display("%s word %0d data=%h last=%0d cnt=%0d", name, w, frame_q[w], is_last, match_cnt);
            if (is_last) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                check_val("done_one_cycle", 32'(done), 0);
                check_val("ready_after_done", 32'(in_ready), 1);
                check_val("cnt_hold", 32'(match_cnt), 32'(cnt));
                check_val("hit_after_done", 32'(hit), 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(in_ready), 1);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_hit", 32'(hit), 0);
        check_val("rst_cnt", 32'(match_cnt), 0);
        reset = 1'b0;

        frame_q = '{8'b1011_0000};
        run_frame("single_b0", 1'b0);
        frame_q = '{8'b1011_0110};
        run_frame("overlap_b6", 1'b0);
        frame_q = '{8'b0000_0101, 8'b1000_0000};
        run_frame("span", 1'b0);
        frame_q = '{8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hBB};
        run_frame("saturate", 1'b0);
        frame_q = '{8'b0000_0000};
        run_frame("clear_next", 1'b0);
        frame_q = '{8'b0000_0101};
        run_frame("tail_101", 1'b0);
        frame_q = '{8'b1000_0000};
        run_frame("no_carry", 1'b0);

        // Reset mid-shift after the first match has been counted.
        in_valid = 1'b1;
        in_data  = 8'b1011_1011;
        in_last  = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("pre_rst_cnt", 32'(match_cnt), 1);
        reset = 1'b1;
        #1;
        check_val("midrst_ready", 32'(in_ready), 1);
        check_val("midrst_busy", 32'(busy), 0);
        check_val("midrst_hit", 32'(hit), 0);
        check_val("midrst_cnt", 32'(match_cnt), 0);
        check_val("midrst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        check_val("midrst_no_done", 32'(done), 0);
        reset = 1'b0;
        $display("mid-shift reset applied");
        frame_q = '{8'b1011_0000};
        run_frame("after_rst", 1'b0);

        for (int f = 0; f < 30; f++) begin
            int nw = $urandom_range(1, 4);
            frame_q = {};
            for (int w = 0; w < nw; w++) begin
                case ($urandom_range(0, 4))
                    0: frame_q.push_back(8'hBB);
                    1: frame_q.push_back(8'h0B);
                    2: frame_q.push_back(8'h2D);
                    3: frame_q.push_back(8'hB6);
                    default: frame_q.push_back(W'($urandom));
                endcase
            end
            run_frame($sformatf("rand%0d", f), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
